dac_batch_shaper: RTL and testbench
===================================

Name: dac_batch_shaper

Overview:
- Sits directly downstream of the DAC interface batch source, in the dac_clk domain.
- Accepts full sample batches over a valid/ready handshake and applies a per-burst arithmetic right-shift scale.
- Presents the scaled batches to the DAC-facing output register.
- Enforces burst length and halt, reports the number of batches emitted in the current burst, and pulses a done flag when the burst has fully drained.

Parameters:
- DATA_WIDTH, 16, bits per sample (signed two's complement).
- BATCH_SIZE, 16, samples per batch.
- MAX_DAC_BURST_SIZE, 1024, largest finite burst in batches.
- BS_WIDTH, $clog2(MAX_DAC_BURST_SIZE)+1, width of burst size and counter.

Ports:
- dac_clk  input  1  sole clock.
- dac_rst  input  1  synchronous, active-low reset.
- batch_in  input  BATCH_SIZE*DATA_WIDTH  upstream batch; sample i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- batch_in_valid  input  1  upstream batch valid.
- batch_in_ready  output  1  shaper accepts batch_in this cycle.
- scale_factor  input  $clog2(DATA_WIDTH)  right-shift amount, sampled on run.
- burst_size  input  BS_WIDTH  batches per burst, sampled on run; 0 = unlimited.
- run  input  1  one-cycle pulse that starts a burst.
- halt  input  1  one-cycle pulse that stops the current burst.
- dac_batch  output  BATCH_SIZE*DATA_WIDTH  scaled batch to the DAC.
- dac_batch_valid  output  1  dac_batch holds a valid batch.
- dac_rdy  input  1  DAC consumes dac_batch when it is high together with dac_batch_valid.
- halt_counter  output  BS_WIDTH  batches accepted in the current or last burst.
- burst_done  output  1  one-cycle pulse when a burst has fully drained.
- busy  output  1  high in RUN or DRAIN.

Behaviour:
- Reset (dac_rst=0 at a clock edge), from any state:
  - state goes to IDLE;
  - dac_batch, dac_batch_valid, halt_counter, burst_done, busy and the latched configuration all go to 0;
  - batch_in_ready goes to 0;
  - an in-flight batch is discarded.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - batch_in_ready=0.
  - On run=1: latch scale_factor and burst_size, clear halt_counter, go to RUN next cycle.
  - halt is ignored.
- RUN:
  - batch_in_ready = ~dac_batch_valid | dac_rdy. This is a single output register with no bubble under continuous flow.
  - On accept (batch_in_valid & batch_in_ready), in the next cycle:
    - dac_batch holds each sample arithmetically right-shifted by the latched scale (sign-extended), truncated toward negative infinity;
    - dac_batch_valid=1;
    - halt_counter increments by 1.
  - If the accept cycle is not also a DAC consume cycle, the output register is loaded normally.
  - If no accept and dac_rdy=1, dac_batch_valid goes to 0.
  - halt_counter saturates at 2^BS_WIDTH-1 in unlimited mode.
  - Transition to DRAIN when either:
    - burst_size≠0 and the accept makes halt_counter equal burst_size; or
    - halt=1.
  - halt and accept in the same cycle: the batch is accepted, counted and delivered, then the block enters DRAIN.
  - run is ignored.
- DRAIN:
  - batch_in_ready=0.
  - Remain until dac_batch_valid=0 (the last batch has been consumed).
  - Then assert burst_done for exactly 1 cycle and go to IDLE.
  - If dac_batch_valid is already 0 on entry, burst_done fires the cycle after entry.
  - run and halt are ignored.
- halt_counter holds its final value in IDLE until the next run.
- Latency: batch_in to dac_batch is 1 cycle.
- dac_batch is stable while dac_batch_valid=1 and dac_rdy=0.
- busy = (state≠IDLE).

Optional Feature:
- Macro: DAC_BATCH_SHAPER_ROUND_EN.
- Defined:
  - when scale>0, each sample becomes (sample + 2^(scale-1)) >>> scale, computed at DATA_WIDTH+1 bits;
  - the result saturates to the signed DATA_WIDTH maximum on overflow;
  - scale=0 passes samples through unchanged.
- Undefined: plain arithmetic shift (floor); no adder is instantiated.

Test Plan:
- Reset mid-burst:
  - Stimulus: dac_rst=0 for 1 cycle during RUN with dac_batch_valid=1.
  - Response: next cycle state is IDLE, dac_batch_valid=0, halt_counter=0, busy=0.
- Finite burst:
  - Stimulus: run with burst_size=4, scale_factor=0, dac_rdy=1, continuous batches with sample i = 16'hBEEF+i.
  - Response: exactly 4 batches out, identical to input, 1-cycle latency; halt_counter=4; burst_done pulses once; batch_in_ready=0 after the 4th accept.
- Scaling:
  - Stimulus: scale_factor=3, samples {-15, 8, 100, 16'h7FFF}.
  - Response without macro: {-2, 1, 12, 4095}.
  - Response with DAC_BATCH_SHAPER_ROUND_EN: {-2, 1, 13, 4096}.
- Backpressure:
  - Stimulus: burst_size=3, dac_rdy held 0 for 5 cycles after the first output.
  - Response: dac_batch stable, batch_in_ready=0 during the stall; all 3 batches delivered in order, none dropped or duplicated.
- Halt in unlimited mode:
  - Stimulus: burst_size=0, halt asserted in the same cycle as the 7th accept.
  - Response: 7 batches delivered, halt_counter=7, burst_done after the last consume, no 8th accept.
- Run while busy:
  - Stimulus: run pulse in RUN with new scale_factor=5.
  - Response: ignored; scale and counter unchanged until the next run from IDLE.

Source files
------------

// File: rtl/dac_batch_shaper.sv
// Burst-controlled batch shaper: per-burst arithmetic right-shift scale, one output register, burst length/halt control.
// Optional DAC_BATCH_SHAPER_ROUND_EN: round-half-up before the shift, saturating to the signed maximum.
module dac_batch_shaper #(
    parameter int DATA_WIDTH         = 16,
    parameter int BATCH_SIZE         = 16,
    parameter int MAX_DAC_BURST_SIZE = 1024,
    parameter int BS_WIDTH           = $clog2(MAX_DAC_BURST_SIZE) + 1
) (
    input  logic                             dac_clk,
    input  logic                             dac_rst,
    input  logic [BATCH_SIZE*DATA_WIDTH-1:0] batch_in,
    input  logic                             batch_in_valid,
    output logic                             batch_in_ready,
    input  logic [$clog2(DATA_WIDTH)-1:0]    scale_factor,
    input  logic [BS_WIDTH-1:0]              burst_size,
    input  logic                             run,
    input  logic                             halt,
    output logic [BATCH_SIZE*DATA_WIDTH-1:0] dac_batch,
    output logic                             dac_batch_valid,
    input  logic                             dac_rdy,
    output logic [BS_WIDTH-1:0]              halt_counter,
    output logic                             burst_done,
    output logic                             busy
);

    localparam int SW = $clog2(DATA_WIDTH);
    localparam int BW = BATCH_SIZE * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_reg, state_next;
    logic [SW-1:0]       scale_reg;
    logic [BS_WIDTH-1:0] burst_size_reg;
    logic [BS_WIDTH-1:0] halt_counter_reg;
    logic [BS_WIDTH-1:0] count_inc;
    logic [BW-1:0]       dac_batch_reg;
    logic [BW-1:0]       scaled;
    logic                dac_batch_valid_reg;
    logic                burst_done_reg, burst_done_next;
    logic                accept, last_accept, load_cfg;

    assign batch_in_ready = (state_reg == RUN) && (!dac_batch_valid_reg || dac_rdy);
    assign accept         = batch_in_valid && batch_in_ready;

    // Saturating increment keeps unlimited bursts from wrapping the count.
    assign count_inc   = (halt_counter_reg == '1) ? halt_counter_reg : halt_counter_reg + 1'b1;
    assign last_accept = accept && (burst_size_reg != '0) && (count_inc == burst_size_reg);
    assign load_cfg    = (state_reg == IDLE) && run;

    genvar gi;
    generate
        for (gi = 0; gi < BATCH_SIZE; gi++) begin : g_lane
            logic signed [DATA_WIDTH-1:0] sample;
            assign sample = batch_in[gi*DATA_WIDTH +: DATA_WIDTH];
`ifdef DAC_BATCH_SHAPER_ROUND_EN
            logic signed [DATA_WIDTH:0] sample_ext, bias, sum, shifted;
            assign sample_ext = {sample[DATA_WIDTH-1], sample};
            assign bias       = (scale_reg == '0) ? '0
                              : ((DATA_WIDTH+1)'(1) << (scale_reg - 1'b1));
            assign sum        = sample_ext + bias;
            assign shifted    = sum >>> scale_reg;
            // A non-negative result that no longer fits DATA_WIDTH bits clamps to the signed maximum.
            assign scaled[gi*DATA_WIDTH +: DATA_WIDTH] =
                (!shifted[DATA_WIDTH] && shifted[DATA_WIDTH-1])
                    ? {1'b0, {(DATA_WIDTH-1){1'b1}}}
                    : shifted[DATA_WIDTH-1:0];
`else
            assign scaled[gi*DATA_WIDTH +: DATA_WIDTH] = sample >>> scale_reg;
`endif
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        burst_done_next = 1'b0;
        case (state_reg)
            IDLE:    if (run) state_next = RUN;
            RUN:     if (halt || last_accept) state_next = DRAIN;
            DRAIN: begin
                if (!dac_batch_valid_reg) begin
                    state_next      = IDLE;
                    burst_done_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge dac_clk) begin
        if (!dac_rst) begin
            state_reg           <= IDLE;
            scale_reg           <= '0;
            burst_size_reg      <= '0;
            halt_counter_reg    <= '0;
            dac_batch_reg       <= '0;
            dac_batch_valid_reg <= 1'b0;
            burst_done_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            burst_done_reg <= burst_done_next;
            if (load_cfg) begin
                scale_reg        <= scale_factor;
                burst_size_reg   <= burst_size;
                halt_counter_reg <= '0;
            end
            if (accept) begin
                dac_batch_reg       <= scaled;
                dac_batch_valid_reg <= 1'b1;
                halt_counter_reg    <= count_inc;
            end else if (dac_rdy) begin
                dac_batch_valid_reg <= 1'b0;
            end
        end
    end

    assign dac_batch       = dac_batch_reg;
    assign dac_batch_valid = dac_batch_valid_reg;
    assign halt_counter    = halt_counter_reg;
    assign burst_done      = burst_done_reg;
    assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_dac_batch_shaper.sv
// Directed self-checking bench for dac_batch_shaper: reset, finite burst, scaling, backpressure, halt, run-while-busy.
module tb_dac_batch_shaper;

    localparam int DW  = 16;
    localparam int NB  = 16;
    localparam int BW  = DW * NB;
    localparam int BSW = 11;
    localparam int SW  = 4;

    logic           dac_clk = 1'b0;
    logic           dac_rst;
    logic [BW-1:0]  batch_in;
    logic           batch_in_valid;
    logic           batch_in_ready;
    logic [SW-1:0]  scale_factor;
    logic [BSW-1:0] burst_size;
    logic           run;
    logic           halt;
    logic [BW-1:0]  dac_batch;
    logic           dac_batch_valid;
    logic           dac_rdy;
    logic [BSW-1:0] halt_counter;
    logic           burst_done;
    logic           busy;

    always #5 dac_clk = ~dac_clk;

    dac_batch_shaper dut (
        .dac_clk        (dac_clk),
        .dac_rst        (dac_rst),
        .batch_in       (batch_in),
        .batch_in_valid (batch_in_valid),
        .batch_in_ready (batch_in_ready),
        .scale_factor   (scale_factor),
        .burst_size     (burst_size),
        .run            (run),
        .halt           (halt),
        .dac_batch      (dac_batch),
        .dac_batch_valid(dac_batch_valid),
        .dac_rdy        (dac_rdy),
        .halt_counter   (halt_counter),
        .burst_done     (burst_done),
        .busy           (busy)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_acc, n_cons, n_done;
    int            k;
    bit            ident;
    bit            last_acc;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] hold;
    logic [BW-1:0] b;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] make_batch(input logic [DW-1:0] base);
        logic [BW-1:0] r;
        for (int i = 0; i < NB; i++) r[i*DW +: DW] = base + DW'(i);
        return r;
    endfunction

    // One clock: records accept/consume at the edge, then checks the 1-cycle latency.
    task automatic step();
        logic [BW-1:0] sent;
        bit            cons;
        #1;
        last_acc = batch_in_valid && batch_in_ready;
        cons     = dac_batch_valid && dac_rdy;
        sent     = batch_in;
        if (cons) begin
            n_cons++;
            $display("consume #%0d data[15:0]=%0h t=%0t", n_cons, dac_batch[15:0], $time);
            if (ident && exp_q.size() > 0) check("deliver_order", dac_batch, exp_q.pop_front());
        end
        if (last_acc) begin
            n_acc++;
            $display("accept  #%0d data[15:0]=%0h t=%0t", n_acc, sent[15:0], $time);
            if (ident) exp_q.push_back(sent);
        end
        @(posedge dac_clk);
        #1;
        if (burst_done) n_done++;
        if (last_acc) begin
            check("accept_valid", BW'(dac_batch_valid), BW'(1));
            if (ident) check("accept_data", dac_batch, sent);
        end
    endtask

    task automatic start_burst(input logic [SW-1:0] sc, input logic [BSW-1:0] sz);
        scale_factor = sc;
        burst_size   = sz;
        run          = 1'b1;
        n_acc        = 0;
        n_cons       = 0;
        n_done       = 0;
        exp_q.delete();
        step();
        run = 1'b0;
        check("start_busy", BW'(busy), BW'(1));
    endtask

    task automatic drain();
        dac_rdy = 1'b1;
        for (int i = 0; i < 20 && busy; i++) step();
        check("drain_idle", BW'(busy), BW'(0));
        step();
        step();
        check("drain_done_once", BW'(n_done), BW'(1));
    endtask

    initial begin
        dac_rst        = 1'b0;
        batch_in       = '0;
        batch_in_valid = 1'b0;
        scale_factor   = '0;
        burst_size     = '0;
        run            = 1'b0;
        halt           = 1'b0;
        dac_rdy        = 1'b0;
        ident          = 1'b1;
        repeat (3) @(posedge dac_clk);
        #1;
        check("rst_valid", BW'(dac_batch_valid), BW'(0));
        check("rst_busy", BW'(busy), BW'(0));
        check("rst_counter", BW'(halt_counter), BW'(0));
        check("rst_done", BW'(burst_done), BW'(0));
        check("rst_ready", BW'(batch_in_ready), BW'(0));
        check("rst_batch", dac_batch, '0);
        dac_rst = 1'b1;
        step();

        // Finite burst of 4 with identity scale
        start_burst(4'd0, 11'd4);
        dac_rdy        = 1'b1;
        k              = 0;
        batch_in       = make_batch(16'hBEEF);
        batch_in_valid = 1'b1;
        for (int c = 0; c < 8 && k < 4; c++) begin
            step();
            if (last_acc) begin
                k++;
                batch_in = make_batch(16'hBEEF + 16'(k * 256));
            end
        end
        check("fin_ready_after4", BW'(batch_in_ready), BW'(0));
        check("fin_counter", BW'(halt_counter), BW'(4));
        drain();
        check("fin_n_acc", BW'(n_acc), BW'(4));
        check("fin_n_cons", BW'(n_cons), BW'(4));
        check("fin_counter_hold", BW'(halt_counter), BW'(4));
        batch_in_valid = 1'b0;

        // Scaling by 3 with hand-computed results
        ident = 1'b0;
        start_burst(4'd3, 11'd1);
        b              = '0;
        b[15:0]        = 16'hFFF1;
        b[31:16]       = 16'd8;
        b[47:32]       = 16'd100;
        b[63:48]       = 16'h7FFF;
        b[79:64]       = 16'h8000;
        batch_in       = b;
        batch_in_valid = 1'b1;
        dac_rdy        = 1'b0;
        step();
        check("scl_acc", BW'(last_acc), BW'(1));
        hold = dac_batch;
        check("scl_s0", BW'(hold[15:0]), BW'(16'hFFFE));
        check("scl_s1", BW'(hold[31:16]), BW'(16'd1));
`ifdef DAC_BATCH_SHAPER_ROUND_EN
        check("scl_s2", BW'(hold[47:32]), BW'(16'd13));
        check("scl_s3", BW'(hold[63:48]), BW'(16'd4096));
`else
        check("scl_s2", BW'(hold[47:32]), BW'(16'd12));
        check("scl_s3", BW'(hold[63:48]), BW'(16'd4095));
`endif
        check("scl_s4", BW'(hold[79:64]), BW'(16'hF000));
        check("scl_s5", BW'(hold[95:80]), BW'(16'd0));
        batch_in_valid = 1'b0;
        drain();
        ident = 1'b1;

        // Backpressure: 5-cycle stall after the first output
        start_burst(4'd0, 11'd3);
        dac_rdy        = 1'b1;
        k              = 0;
        batch_in       = make_batch(16'h1000);
        batch_in_valid = 1'b1;
        for (int c = 0; c < 4 && k == 0; c++) begin
            step();
            if (last_acc) begin
                k++;
                batch_in = make_batch(16'h1000 + 16'(k * 256));
            end
        end
        dac_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            hold = dac_batch;
            step();
            check("bp_hold", dac_batch, hold);
            check("bp_ready", BW'(batch_in_ready), BW'(0));
            check("bp_valid", BW'(dac_batch_valid), BW'(1));
        end
        dac_rdy = 1'b1;
        for (int c = 0; c < 10 && k < 3; c++) begin
            step();
            if (last_acc) begin
                k++;
                batch_in = make_batch(16'h1000 + 16'(k * 256));
            end
        end
        drain();
        check("bp_n_acc", BW'(n_acc), BW'(3));
        check("bp_n_cons", BW'(n_cons), BW'(3));
        check("bp_counter", BW'(halt_counter), BW'(3));
        batch_in_valid = 1'b0;

        // Halt on the 7th accept in unlimited mode
        start_burst(4'd0, 11'd0);
        dac_rdy        = 1'b1;
        k              = 0;
        batch_in       = make_batch(16'h2000);
        batch_in_valid = 1'b1;
        for (int c = 0; c < 12 && k < 7; c++) begin
            halt = (k == 6);
            step();
            if (halt) check("halt_same_acc", BW'(last_acc), BW'(1));
            halt = 1'b0;
            if (last_acc) begin
                k++;
                batch_in = make_batch(16'h2000 + 16'(k * 256));
            end
        end
        drain();
        check("halt_n_acc", BW'(n_acc), BW'(7));
        check("halt_n_cons", BW'(n_cons), BW'(7));
        check("halt_counter", BW'(halt_counter), BW'(7));
        batch_in_valid = 1'b0;

        // Run pulse while busy must not reload scale, size or counter
        ident = 1'b0;
        start_burst(4'd2, 11'd0);
        dac_rdy         = 1'b1;
        batch_in        = '0;
        batch_in[15:0]  = 16'd64;
        batch_in_valid  = 1'b1;
        step();
        check("rb_acc1", BW'(last_acc), BW'(1));
        check("rb_data1", BW'(dac_batch[15:0]), BW'(16'd16));
        batch_in_valid = 1'b0;
        scale_factor   = 4'd5;
        burst_size     = 11'd2;
        run            = 1'b1;
        step();
        run = 1'b0;
        check("rb_busy", BW'(busy), BW'(1));
        check("rb_counter1", BW'(halt_counter), BW'(1));
        batch_in_valid = 1'b1;
        step();
        check("rb_data2", BW'(dac_batch[15:0]), BW'(16'd16));
        check("rb_counter2", BW'(halt_counter), BW'(2));
        check("rb_still_run", BW'(busy && batch_in_ready), BW'(1));
        batch_in_valid = 1'b0;
        halt = 1'b1;
        step();
        halt = 1'b0;
        drain();
        ident = 1'b1;

        // Reset in the middle of a burst with a batch held
        start_burst(4'd0, 11'd0);
        dac_rdy        = 1'b0;
        batch_in       = make_batch(16'h3000);
        batch_in_valid = 1'b1;
        step();
        check("mid_valid_before", BW'(dac_batch_valid), BW'(1));
        batch_in_valid = 1'b0;
        dac_rst        = 1'b0;
        step();
        check("mid_valid", BW'(dac_batch_valid), BW'(0));
        check("mid_counter", BW'(halt_counter), BW'(0));
        check("mid_busy", BW'(busy), BW'(0));
        check("mid_ready", BW'(batch_in_ready), BW'(0));
        check("mid_batch", dac_batch, '0);
        dac_rst = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
